prbs5_checker: RTL and testbench

PRBS5_CHECKER -- requirements
Module: prbs5_checker

---
 rtl/prbs5_checker.sv | 166 ++++++++++++++++
 tb/tb_prbs5_checker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs5_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs5_checker
//  Purpose  : Checks a stream of 5-bit LFSR states against the x^5+x^2+1
//             sequence (period 31). Seeds from the first non-zero sample,
//             acquires lock after LOCK_CNT consecutive matches, then runs
//             as a flywheel: mismatches are counted without disturbing the
//             local sequence until LOSS_THRESH consecutive misses force a
//             re-acquisition.
//  Ports    : clk      - clock, all state updates on rising edge
//             rst_b    - asynchronous active-low reset
//             en       - sample qualifier; din examined only when en=1
//             din[4:0] - upstream LFSR state sample, bit 4 = MSB
//             locked   - high while in LOCK
//             err      - one-cycle pulse after each counted mismatch
//             err_cnt  - saturating mismatch count (LOCK only)
//             wrap     - one-cycle pulse per 31 consecutive LOCK samples
//  Revision : 1.0 - initial release
// ============================================================================
module prbs5_checker #(
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned LOSS_THRESH = 3
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       en,
   input  logic [4:0] din,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic       wrap
);

   typedef enum logic [1:0] {
      ST_SEED = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [3:0] C_LOCK_CNT    = 4'(LOCK_CNT);
   localparam logic [3:0] C_LOSS_THRESH = 4'(LOSS_THRESH);
   localparam logic [4:0] C_SCNT_LAST   = 5'd30;

   // One step of x^5+x^2+1: bit 4 feeds back into bit 0 and is XORed into bit 2.
   function automatic logic [4:0] step5(input logic [4:0] s);
      return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
   endfunction

   state_t     state_q, state_d;
   logic [4:0] exp_q, exp_d;
   logic [3:0] match_run_q, match_run_d;
   logic [3:0] miss_run_q, miss_run_d;
   logic [4:0] scnt_q, scnt_d;
   logic       locked_q, locked_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       wrap_q, wrap_d;

   logic [3:0] w_match_inc;
   logic [3:0] w_miss_inc;

   assign w_match_inc = match_run_q + 4'd1;
   assign w_miss_inc  = miss_run_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      match_run_d = match_run_q;
      miss_run_d  = miss_run_q;
      scnt_d      = scnt_q;
      locked_d    = locked_q;
      err_cnt_d   = err_cnt_q;
      err_d       = 1'b0;
      wrap_d      = 1'b0;

      if (en) begin
         case (state_q)
            ST_SEED: begin
               // An all-zero sample is the LFSR lock-up state and cannot seed.
               if (din != 5'd0) begin
                  exp_d       = step5(din);
                  match_run_d = 4'd0;
                  state_d     = ST_ACQ;
               end
            end

            ST_ACQ: begin
               if (din == exp_q) begin
                  exp_d       = step5(din);
                  match_run_d = w_match_inc;
                  if (w_match_inc == C_LOCK_CNT) begin
                     state_d    = ST_LOCK;
                     locked_d   = 1'b1;
                     scnt_d     = 5'd0;
                     miss_run_d = 4'd0;
                  end
               end else begin
                  state_d = ST_SEED;
               end
            end

            ST_LOCK: begin
               // Flywheel: the expected sequence advances from its own state,
               // never from din, so a corrupted sample cannot derail it.
               exp_d = step5(exp_q);
               if (scnt_q == C_SCNT_LAST) begin
                  scnt_d = 5'd0;
                  wrap_d = 1'b1;
               end else begin
                  scnt_d = scnt_q + 5'd1;
               end

               if (din == exp_q) begin
                  miss_run_d = 4'd0;
               end else begin
                  err_d      = 1'b1;
                  miss_run_d = w_miss_inc;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
                  if (w_miss_inc == C_LOSS_THRESH) begin
                     state_d  = ST_SEED;
                     locked_d = 1'b0;
                  end
               end
            end

            default: begin
               state_d  = ST_SEED;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_SEED;
         exp_q       <= 5'd0;
         match_run_q <= 4'd0;
         miss_run_q  <= 4'd0;
         scnt_q      <= 5'd0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= 8'd0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         match_run_q <= match_run_d;
         miss_run_q  <= miss_run_d;
         scnt_q      <= scnt_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         wrap_q      <= wrap_d;
      end
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs5_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs5_checker
//  Purpose  : Self-checking bench for prbs5_checker (LOCK_CNT=4,
//             LOSS_THRESH=3). A hand-derived vector table covers the first
//             lock and a single error; a reference model feeding a
//             scoreboard queue covers clean streams, loss/re-lock,
//             acquisition miss, en gating, saturation and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs5_checker;

   localparam int LOCK_CNT    = 4;
   localparam int LOSS_THRESH = 3;

   logic       clk;
   logic       rst_b;
   logic       en;
   logic [4:0] din;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;
   logic       wrap;

   prbs5_checker #(
      .LOCK_CNT   (LOCK_CNT),
      .LOSS_THRESH(LOSS_THRESH)
   ) dut (
      .clk    (clk),
      .rst_b  (rst_b),
      .en     (en),
      .din    (din),
      .locked (locked),
      .err    (err),
      .err_cnt(err_cnt),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       locked;
      logic       err;
      logic       wrap;
      logic [7:0] err_cnt;
   } obs_t;

   typedef struct {
      logic       en;
      logic [4:0] din;
      obs_t       expv;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   obs_t exp_q[$];

   // Reference model state
   int         m_state;   // 0 seed, 1 acquire, 2 lock
   logic [4:0] m_exp;
   int         m_match;
   int         m_miss;
   int         m_scnt;
   obs_t       m_obs;

   function automatic logic [4:0] nxt(input logic [4:0] s);
      return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_exp   = 5'd0;
      m_match = 0;
      m_miss  = 0;
      m_scnt  = 0;
      m_obs   = '0;
   endtask

   task automatic model_clock(input logic e, input logic [4:0] d);
      m_obs.err  = 1'b0;
      m_obs.wrap = 1'b0;
      if (e) begin
         if (m_state == 0) begin
            if (d != 5'd0) begin
               m_exp   = nxt(d);
               m_match = 0;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (d == m_exp) begin
               m_exp   = nxt(d);
               m_match = m_match + 1;
               if (m_match == LOCK_CNT) begin
                  m_state      = 2;
                  m_obs.locked = 1'b1;
                  m_scnt       = 0;
                  m_miss       = 0;
               end
            end else begin
               m_state = 0;
            end
         end else begin
            if (d != m_exp) begin
               m_obs.err = 1'b1;
               if (m_obs.err_cnt != 8'd255) m_obs.err_cnt = m_obs.err_cnt + 8'd1;
               m_miss = m_miss + 1;
            end else begin
               m_miss = 0;
            end
            m_exp  = nxt(m_exp);
            m_scnt = m_scnt + 1;
            if (m_scnt == 31) begin
               m_scnt     = 0;
               m_obs.wrap = 1'b1;
            end
            if (m_miss == LOSS_THRESH) begin
               m_state      = 0;
               m_obs.locked = 1'b0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks = checks + 1;
      if (act != req) begin
         failures = failures + 1;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Pops the oldest expected observation and compares it with the DUT.
   task automatic check_obs(input string name);
      obs_t e;
      obs_t a;
      checks = checks + 1;
      a = '{locked: locked, err: err, wrap: wrap, err_cnt: err_cnt};
      if (exp_q.size() == 0) begin
         failures = failures + 1;
         $display("FAIL %s: scoreboard empty, actual=%h", name, a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            failures = failures + 1;
            $display("FAIL %s: actual locked=%b err=%b wrap=%b err_cnt=%0d required locked=%b err=%b wrap=%b err_cnt=%0d",
                     name, a.locked, a.err, a.wrap, a.err_cnt, e.locked, e.err, e.wrap, e.err_cnt);
         end
      end
   endtask

   task automatic drive(input logic e, input logic [4:0] d, input obs_t expv, input string name);
      @(negedge clk);
      en  = e;
      din = d;
      exp_q.push_back(expv);
      @(posedge clk);
      #1;
      check_obs(name);
   endtask

   task automatic run(input logic e, input logic [4:0] d, input string name);
      model_clock(e, d);
      drive(e, d, m_obs, name);
   endtask

   // Asserts reset between clock edges and checks outputs clear at once.
   task automatic do_reset(input string name);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #3;
      rst_b = 1'b0;
      #1;
      chk({name, "_locked"},  int'(locked),  0);
      chk({name, "_err"},     int'(err),     0);
      chk({name, "_wrap"},    int'(wrap),    0);
      chk({name, "_err_cnt"}, int'(err_cnt), 0);
      @(negedge clk);
      rst_b = 1'b1;
      model_reset();
   endtask

   vec_t       vecs[9];
   logic [4:0] g;
   int         first_wrap;
   int         cnt_before;

   initial begin
      rst_b = 1'b0;
      en    = 1'b0;
      din   = 5'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_locked",  int'(locked),  0);
      chk("reset_err_cnt", int'(err_cnt), 0);
      @(negedge clk);
      rst_b = 1'b1;

      // Hand-derived: seed 11111, four matches, lock, then one corrupted sample.
      vecs[0] = '{1'b1, 5'b11111, '{1'b0, 1'b0, 1'b0, 8'd0}};
      vecs[1] = '{1'b1, 5'b11011, '{1'b0, 1'b0, 1'b0, 8'd0}};
      vecs[2] = '{1'b1, 5'b10011, '{1'b0, 1'b0, 1'b0, 8'd0}};
      vecs[3] = '{1'b1, 5'b00011, '{1'b0, 1'b0, 1'b0, 8'd0}};
      vecs[4] = '{1'b1, 5'b00110, '{1'b1, 1'b0, 1'b0, 8'd0}};
      vecs[5] = '{1'b1, 5'b01100, '{1'b1, 1'b0, 1'b0, 8'd0}};
      vecs[6] = '{1'b1, 5'b00000, '{1'b1, 1'b1, 1'b0, 8'd1}};
      vecs[7] = '{1'b1, 5'b10101, '{1'b1, 1'b0, 1'b0, 8'd1}};
      vecs[8] = '{1'b0, 5'b01010, '{1'b1, 1'b0, 1'b0, 8'd1}};
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].en, vecs[i].din, vecs[i].expv, $sformatf("table_%0d", i));
      end

      // Clean stream from 11111: lock on the 5th edge, wrap 31 edges later.
      do_reset("rst_a");
      g          = 5'b11111;
      first_wrap = -1;
      for (int i = 0; i < 40; i++) begin
         run(1'b1, g, "clean");
         if (wrap && first_wrap < 0) first_wrap = i;
         g = nxt(g);
      end
      chk("first_wrap_edge", first_wrap, 35);

      // Single error while locked, then clean sample matches.
      cnt_before = int'(err_cnt);
      run(1'b1, 5'd0, "single_err");
      g = nxt(g);
      run(1'b1, g, "after_err");
      g = nxt(g);
      chk("single_err_cnt", int'(err_cnt), cnt_before + 1);
      chk("single_err_locked", int'(locked), 1);

      // Three consecutive misses lose lock, then re-lock.
      for (int i = 0; i < 3; i++) begin
         run(1'b1, 5'd0, "loss");
         g = nxt(g);
      end
      chk("loss_locked", int'(locked), 0);
      chk("loss_err_cnt", int'(err_cnt), cnt_before + 4);
      for (int i = 0; i < 5; i++) begin
         run(1'b1, g, "relock");
         g = nxt(g);
      end
      chk("relock_locked", int'(locked), 1);

      // Acquisition miss on the 3rd ACQ sample.
      do_reset("rst_b");
      g = 5'b11111;
      run(1'b1, g, "acq_seed");
      g = nxt(g);
      run(1'b1, g, "acq_m1");
      g = nxt(g);
      run(1'b1, g, "acq_m2");
      g = nxt(g);
      run(1'b1, g ^ 5'b00001, "acq_miss");
      g = nxt(g);
      chk("acq_miss_locked", int'(locked), 0);
      chk("acq_miss_err_cnt", int'(err_cnt), 0);
      for (int i = 0; i < 6; i++) begin
         run(1'b1, g, "acq_recover");
         g = nxt(g);
      end

      // Zero seed ignored, then en-gated clean stream.
      do_reset("rst_c");
      for (int i = 0; i < 3; i++) run(1'b1, 5'd0, "zero_seed");
      g = 5'b10110;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            run(1'b1, g, "gated_on");
            g = nxt(g);
         end else begin
            run(1'b0, 5'($urandom), "gated_off");
         end
      end
      for (int i = 0; i < 6; i++) begin
         run(1'b1, g, "gated_tail");
         g = nxt(g);
      end
      chk("gated_locked", int'(locked), 1);

      // 300 isolated errors saturate err_cnt without losing lock.
      for (int i = 0; i < 300; i++) begin
         run(1'b1, 5'd0, "sat_err");
         g = nxt(g);
         run(1'b1, g, "sat_ok");
         g = nxt(g);
      end
      chk("sat_err_cnt", int'(err_cnt), 255);
      chk("sat_locked", int'(locked), 1);

      // Mid-stream async reset, then clean re-lock.
      do_reset("rst_d");
      g = 5'b00101;
      for (int i = 0; i < 6; i++) begin
         run(1'b1, g, "post_reset");
         g = nxt(g);
      end
      chk("post_reset_locked", int'(locked), 1);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
